// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I instruction-decode stage.
//   Decodes instruction_i into an immediate plus control bundle, latches the
//   result into an ID/EX output register under a valid/ready handshake,
//   interlocks on load-use hazards through a load-destination scoreboard and
//   traps on illegal encodings until flush_i.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   instr_valid_i / instr_ready_o / instruction_i / pc_i : IF/ID side
//   flush_i                                              : kill stage contents
//   ex_ready_i / ex_valid_o                              : ID/EX handshake
//   pc_o, imm_o, rs1_o, rs2_o, rd_o, funct3_o            : registered fields
//   alusrc1_o, alusrc2_o, dmem_to_reg_o, reg_write_o, mem_read_o,
//   mem_write_o, branch_o, jump_o, alu_op_o, illegal_o   : registered controls
//   stall_o                                              : stage is interlocked
// Build option: define PSRV_RV32M_EN to decode the RV32M multiply/divide group
//   (alu_op = 16 + funct3); otherwise those encodings are illegal.
module decode_ctrl_pipe #(
  parameter int          XLEN     = 32,
  parameter int          ALU_OP_W = 6,
  parameter int unsigned LU_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [31:0]         instruction_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                ex_valid_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     imm_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o,
  output logic [2:0]          funct3_o,
  output logic                alusrc1_o,
  output logic                alusrc2_o,
  output logic [1:0]          dmem_to_reg_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o,
  output logic                stall_o
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BXX   = 7'b1100011;
  localparam logic [6:0] OP_LXX   = 7'b0000011;
  localparam logic [6:0] OP_SXX   = 7'b0100011;
  localparam logic [6:0] OP_IXX   = 7'b0010011;
  localparam logic [6:0] OP_RXX   = 7'b0110011;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_BAD  = ALU_OP_W'(15);

  typedef enum logic [1:0] {RUN, INTERLOCK, TRAP} state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  state_t    state, state_next;
  sb_entry_t sb [LU_DEPTH];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] f_rs1, f_rs2;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, d_imm32;
  logic d_alusrc1, d_alusrc2, d_rw, d_mr, d_mw, d_br, d_jp, d_ill;
  logic [1:0] d_d2r;
  logic [ALU_OP_W-1:0] d_op;
  logic uses_rs1, uses_rs2, rd_zero;
  logic rs1_busy, rs2_busy, hazard, adv, accept, load_xfer;

  assign opc   = instruction_i[6:0];
  assign f3    = instruction_i[14:12];
  assign f7    = instruction_i[31:25];
  assign f_rs1 = instruction_i[19:15];
  assign f_rs2 = instruction_i[24:20];

  assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                  instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign imm_u = {instruction_i[31:12], 12'b0};
  assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                  instruction_i[20], instruction_i[30:21], 1'b0};

  always_comb begin
    d_imm32   = '0;
    d_alusrc1 = 1'b0;
    d_alusrc2 = 1'b0;
    d_d2r     = 2'b01;
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_jp      = 1'b0;
    d_op      = ALU_ADD;
    d_ill     = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    rd_zero   = 1'b0;
    case (opc)
      OP_LUI:   begin d_imm32 = imm_u; d_d2r = 2'b11; d_rw = 1'b1; uses_rs1 = 1'b0; end
      OP_AUIPC: begin
        d_imm32 = imm_u; d_alusrc1 = 1'b1; d_alusrc2 = 1'b1; d_rw = 1'b1; uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        d_imm32 = imm_j; d_alusrc1 = 1'b1; d_alusrc2 = 1'b1; d_d2r = 2'b10;
        d_rw = 1'b1; d_jp = 1'b1; uses_rs1 = 1'b0;
      end
      OP_JALR:  begin d_imm32 = imm_i; d_alusrc2 = 1'b1; d_d2r = 2'b10; d_rw = 1'b1; d_jp = 1'b1; end
      OP_BXX: begin
        d_imm32 = imm_b; d_br = 1'b1; uses_rs2 = 1'b1; rd_zero = 1'b1;
        case (f3)
          3'd0, 3'd1: d_op = ALU_SUB;
          3'd4, 3'd5: d_op = ALU_SLT;
          3'd6, 3'd7: d_op = ALU_SLTU;
          default:    d_ill = 1'b1;
        endcase
      end
      OP_LXX:   begin d_imm32 = imm_i; d_alusrc2 = 1'b1; d_d2r = 2'b00; d_rw = 1'b1; d_mr = 1'b1; end
      OP_SXX:   begin d_imm32 = imm_s; d_alusrc2 = 1'b1; d_mw = 1'b1; uses_rs2 = 1'b1; rd_zero = 1'b1; end
      OP_IXX: begin
        d_imm32 = imm_i; d_alusrc2 = 1'b1; d_rw = 1'b1;
        d_op = (f3 == 3'd5 && instruction_i[30]) ? ALU_SRA : ALU_OP_W'(f3);
      end
      OP_RXX: begin
        uses_rs2 = 1'b1; d_rw = 1'b1;
        case (f7)
          7'b0000000: d_op = ALU_OP_W'(f3);
          7'b0100000: begin
            if (f3 == 3'd0)      d_op = ALU_SUB;
            else if (f3 == 3'd5) d_op = ALU_SRA;
            else                 d_ill = 1'b1;
          end
`ifdef PSRV_RV32M_EN
          7'b0000001: d_op = ALU_OP_W'(5'd16 + 5'(f3));
`endif
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal entries carry no side effects into EX, whatever the opcode path set.
    if (d_ill) begin
      d_imm32   = '0;
      d_alusrc1 = 1'b0;
      d_alusrc2 = 1'b0;
      d_d2r     = 2'b00;
      d_rw      = 1'b0;
      d_mr      = 1'b0;
      d_mw      = 1'b0;
      d_br      = 1'b0;
      d_jp      = 1'b0;
      d_op      = ALU_BAD;
    end
  end

  // A source is busy if a recent load (scoreboard) or the load now sitting in
  // the output register will write it.
  always_comb begin
    rs1_busy = ex_valid_o & mem_read_o & (rd_o == f_rs1);
    rs2_busy = ex_valid_o & mem_read_o & (rd_o == f_rs2);
    for (int unsigned i = 0; i < LU_DEPTH; i++) begin
      if (sb[i].v && sb[i].rd == f_rs1) rs1_busy = 1'b1;
      if (sb[i].v && sb[i].rd == f_rs2) rs2_busy = 1'b1;
    end
  end

  assign hazard = instr_valid_i &
                  ((uses_rs1 & (f_rs1 != 5'd0) & rs1_busy) |
                   (uses_rs2 & (f_rs2 != 5'd0) & rs2_busy));

  assign adv           = ~ex_valid_o | ex_ready_i;
  assign instr_ready_o = (state == RUN) & adv & ~hazard & ~flush_i & ~reset_i;
  assign accept        = instr_valid_i & instr_ready_o;
  assign load_xfer     = ex_valid_o & ex_ready_i & mem_read_o & (rd_o != 5'd0);
  assign stall_o       = (state == INTERLOCK);

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (instr_valid_i && hazard)  state_next = INTERLOCK;
        else if (accept && d_ill)     state_next = TRAP;
      end
      INTERLOCK: if (!hazard) state_next = RUN;
      TRAP:      state_next = TRAP;
      default:   state_next = RUN;
    endcase
    if (flush_i) state_next = RUN;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int unsigned i = 0; i < LU_DEPTH; i++) sb[i] <= '0;
    end else if (ex_ready_i) begin
      for (int unsigned i = 1; i < LU_DEPTH; i++) sb[i] <= sb[i-1];
      sb[0] <= '{v: load_xfer, rd: rd_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ex_valid_o    <= 1'b0;
      pc_o          <= '0;
      imm_o         <= '0;
      rs1_o         <= '0;
      rs2_o         <= '0;
      rd_o          <= '0;
      funct3_o      <= '0;
      alusrc1_o     <= 1'b0;
      alusrc2_o     <= 1'b0;
      dmem_to_reg_o <= '0;
      reg_write_o   <= 1'b0;
      mem_read_o    <= 1'b0;
      mem_write_o   <= 1'b0;
      branch_o      <= 1'b0;
      jump_o        <= 1'b0;
      alu_op_o      <= '0;
      illegal_o     <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o    <= 1'b1;
      pc_o          <= pc_i;
      imm_o         <= XLEN'(d_imm32);
      rs1_o         <= f_rs1;
      rs2_o         <= f_rs2;
      rd_o          <= rd_zero ? 5'd0 : instruction_i[11:7];
      funct3_o      <= f3;
      alusrc1_o     <= d_alusrc1;
      alusrc2_o     <= d_alusrc2;
      dmem_to_reg_o <= d_d2r;
      reg_write_o   <= d_rw;
      mem_read_o    <= d_mr;
      mem_write_o   <= d_mw;
      branch_o      <= d_br;
      jump_o        <= d_jp;
      alu_op_o      <= d_op;
      illegal_o     <= d_ill;
    end else if (adv) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: self-checking bench for decode_ctrl_pipe.
// Directed scenarios followed by random traffic, all compared each cycle
// against a behavioural model (decode rules + in-flight load list).
module tb_decode_ctrl_pipe;
  localparam int LU_DEPTH = 2;

  logic clk = 1'b0;
  logic reset_i, instr_valid_i, instr_ready_o, flush_i, ex_ready_i, ex_valid_o;
  logic [31:0] instruction_i, pc_i, pc_o, imm_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [2:0] funct3_o;
  logic alusrc1_o, alusrc2_o, reg_write_o, mem_read_o, mem_write_o;
  logic branch_o, jump_o, illegal_o, stall_o;
  logic [1:0] dmem_to_reg_o;
  logic [5:0] alu_op_o;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.XLEN(32), .ALU_OP_W(6), .LU_DEPTH(LU_DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .instruction_i(instruction_i), .pc_i(pc_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
    .pc_o(pc_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .alusrc1_o(alusrc1_o), .alusrc2_o(alusrc2_o),
    .dmem_to_reg_o(dmem_to_reg_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .jump_o(jump_o), .alu_op_o(alu_op_o), .illegal_o(illegal_o), .stall_o(stall_o)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        s1, s2;
    logic [1:0]  d2r;
    logic        rw, mr, mw, br, jp;
    logic [5:0]  op;
    logic        ill, use1, use2;
  } dec_t;

  typedef struct { logic [4:0] rd; int age; } ld_t;

  int   checks = 0;
  int   failures = 0;
  dec_t m_d;
  logic [31:0] m_pc;
  logic m_valid;
  int   m_st;          // 0 running, 1 interlocked, 2 trapped
  ld_t  ld_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode rules written from the ISA view: class by opcode, then fill fields.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] sw;
    logic [31:0] im_i, im_s, im_b, im_u, im_j;
    bit m_en;
`ifdef PSRV_RV32M_EN
    m_en = 1'b1;
`else
    m_en = 1'b0;
`endif
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; sw = w;
    im_i = 32'(sw >>> 20);
    im_s = (32'(sw >>> 20) & ~32'h1f) | 32'(w[11:7]);
    im_b = (32'(sw >>> 19) & ~32'hfff) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    im_u = w & 32'hffff_f000;
    im_j = (32'(sw >>> 11) & 32'hfff0_0000) | (w & 32'h000f_f000) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    d = '0;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.f3 = f3;
    d.d2r = 2'b01; d.use1 = 1'b1;
    case (opc)
      7'h37: begin d.imm = im_u; d.d2r = 2'b11; d.rw = 1; d.use1 = 0; end
      7'h17: begin d.imm = im_u; d.s1 = 1; d.s2 = 1; d.rw = 1; d.use1 = 0; end
      7'h6f: begin d.imm = im_j; d.s1 = 1; d.s2 = 1; d.d2r = 2'b10; d.rw = 1; d.jp = 1; d.use1 = 0; end
      7'h67: begin d.imm = im_i; d.s2 = 1; d.d2r = 2'b10; d.rw = 1; d.jp = 1; end
      7'h63: begin
        d.imm = im_b; d.br = 1; d.rd = 0; d.use2 = 1;
        if (f3 == 0 || f3 == 1)      d.op = 9;
        else if (f3 == 4 || f3 == 5) d.op = 2;
        else if (f3 == 6 || f3 == 7) d.op = 3;
        else                         d.ill = 1;
      end
      7'h03: begin d.imm = im_i; d.s2 = 1; d.d2r = 2'b00; d.rw = 1; d.mr = 1; end
      7'h23: begin d.imm = im_s; d.s2 = 1; d.mw = 1; d.rd = 0; d.use2 = 1; end
      7'h13: begin d.imm = im_i; d.s2 = 1; d.rw = 1; d.op = (f3 == 5 && w[30]) ? 6'd8 : 6'(f3); end
      7'h33: begin
        d.use2 = 1; d.rw = 1;
        if (f7 == 0)                    d.op = 6'(f3);
        else if (f7 == 7'h20 && f3 == 0) d.op = 9;
        else if (f7 == 7'h20 && f3 == 5) d.op = 8;
        else if (f7 == 7'h01 && m_en)    d.op = 6'(16 + int'(f3));
        else                             d.ill = 1;
      end
      default: d.ill = 1;
    endcase
    if (d.ill) begin
      d.imm = 0; d.s1 = 0; d.s2 = 0; d.d2r = 0;
      d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.jp = 0; d.op = 15;
    end
    return d;
  endfunction

  function automatic bit busy(input logic [4:0] r);
    if (m_valid && m_d.mr && m_d.rd == r) return 1'b1;
    foreach (ld_q[i]) if (ld_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_d = '0; m_pc = '0; m_valid = 1'b0; m_st = 0; ld_q.delete();
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic exr, input logic rst);
    dec_t nd;
    bit hz, rdy, acc;
    ld_t nq[$];
    instr_valid_i = v; instruction_i = ins; pc_i = pc;
    flush_i = fl; ex_ready_i = exr; reset_i = rst;
    @(negedge clk);
    nd  = ref_decode(ins);
    hz  = v && ((nd.use1 && nd.rs1 != 0 && busy(nd.rs1)) || (nd.use2 && nd.rs2 != 0 && busy(nd.rs2)));
    rdy = (m_st == 0) && (!m_valid || exr) && !hz && !fl && !rst;
    chk("instr_ready", 32'(instr_ready_o), 32'(rdy));
    chk("stall", 32'(stall_o), 32'(m_st == 1));
    chk("ex_valid", 32'(ex_valid_o), 32'(m_valid));
    chk("pc", pc_o, m_pc);
    chk("imm", imm_o, m_d.imm);
    chk("rs1", 32'(rs1_o), 32'(m_d.rs1));
    chk("rs2", 32'(rs2_o), 32'(m_d.rs2));
    chk("rd", 32'(rd_o), 32'(m_d.rd));
    chk("funct3", 32'(funct3_o), 32'(m_d.f3));
    chk("ctrl", 32'({alusrc1_o, alusrc2_o, dmem_to_reg_o, reg_write_o, mem_read_o,
                     mem_write_o, branch_o, jump_o, illegal_o}),
                32'({m_d.s1, m_d.s2, m_d.d2r, m_d.rw, m_d.mr, m_d.mw, m_d.br, m_d.jp, m_d.ill}));
    chk("alu_op", 32'(alu_op_o), 32'(m_d.op));
    if (rst) begin
      model_reset();
    end else if (fl) begin
      m_valid = 1'b0; ld_q.delete(); m_st = 0;
    end else begin
      acc = v && rdy;
      if (m_st == 0) begin
        if (v && hz)          m_st = 1;
        else if (acc && nd.ill) m_st = 2;
      end else if (m_st == 1 && !hz) begin
        m_st = 0;
      end
      if (exr) begin
        foreach (ld_q[i]) if (ld_q[i].age + 1 < LU_DEPTH) nq.push_back('{ld_q[i].rd, ld_q[i].age + 1});
        if (m_valid && m_d.mr && m_d.rd != 0) nq.push_back('{m_d.rd, 0});
        ld_q = nq;
      end
      if (acc) begin
        m_d = nd; m_pc = pc; m_valid = 1'b1;
      end else if (!m_valid || exr) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 11);
    w[6:0] = (sel < 9) ? ops[sel] : ((sel == 9) ? 7'h33 : 7'(w[6:0] | 7'h7c));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  localparam logic [31:0] ADDI  = {12'd5, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] SUB   = {7'h20, 5'd3, 5'd1, 3'd0, 5'd2, 7'h33};
  localparam logic [31:0] LW5   = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
  localparam logic [31:0] ADD5  = {7'h00, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33};
  localparam logic [31:0] LW0   = {12'd0, 5'd1, 3'd2, 5'd0, 7'h03};
  localparam logic [31:0] ADD0  = {7'h00, 5'd7, 5'd0, 3'd0, 5'd6, 7'h33};
  localparam logic [31:0] BLT   = {7'h00, 5'd2, 5'd1, 3'd4, 4'd4, 1'b0, 7'h63};
  localparam logic [31:0] ILL   = 32'h0000_007f;
  localparam logic [31:0] MUL   = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};

  initial begin
    bit seen;
    reset_i = 1'b1; instr_valid_i = 1'b0; instruction_i = '0; pc_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // back-to-back ADDI / SUB
    step(1, ADDI, 32'h100, 0, 1, 0);
    chk("addi_alu", 32'(alu_op_o), 32'd0);
    chk("addi_imm", imm_o, 32'd5);
    step(1, SUB, 32'h104, 0, 1, 0);
    chk("sub_alu", 32'(alu_op_o), 32'd9);
    chk("sub_imm", imm_o, 32'd0);
    chk("sub_valid", 32'(ex_valid_o), 32'd1);

    // reset mid-stream
    step(1, ADDI, 32'h108, 0, 1, 1);
    chk("rst_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_rw", 32'(reg_write_o), 32'd0);
    step(0, 0, 0, 0, 1, 0);

    // load-use interlock, then the rd=x0 variant
    step(1, LW5, 32'h200, 0, 1, 0);
    seen = 0;
    repeat (6) begin step(1, ADD5, 32'h204, 0, 1, 0); seen |= stall_o; end
    chk("lu_stall_seen", 32'(seen), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    step(1, LW0, 32'h300, 0, 1, 0);
    seen = 0;
    repeat (4) begin step(1, ADD0, 32'h304, 0, 1, 0); seen |= stall_o; end
    chk("x0_no_stall", 32'(seen), 32'd0);

    // BLT held while EX is stalled
    step(1, BLT, 32'h400, 0, 1, 0);
    repeat (3) begin
      step(1, ADDI, 32'h404, 0, 0, 0);
      chk("blt_alu", 32'(alu_op_o), 32'd2);
      chk("blt_branch", 32'(branch_o), 32'd1);
    end
    step(1, ADDI, 32'h404, 0, 1, 0);

    // illegal opcode traps until flush
    step(1, ILL, 32'h500, 0, 1, 0);
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_alu", 32'(alu_op_o), 32'd15);
    repeat (3) step(1, ADDI, 32'h504, 0, 1, 0);
    step(1, ADDI, 32'h504, 1, 0, 0);
    chk("flush_valid", 32'(ex_valid_o), 32'd0);
    step(1, ADDI, 32'h508, 0, 1, 0);

    // M-extension encoding
    step(1, MUL, 32'h600, 0, 1, 0);
`ifdef PSRV_RV32M_EN
    chk("mul_alu", 32'(alu_op_o), 32'd16);
`else
    chk("mul_illegal", 32'(illegal_o), 32'd1);
`endif
    step(0, 0, 0, 1, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 8, rand_instr(), $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
